kb_event_fifo: RTL and testbench

- Sits between kb_driver and the memory-mapped keyboard register and CPU interrupt line.
- Turns the level-type `ascii` output of kb_driver into discrete key events, including typematic repeat.
- Queues the events in a small first-word-fall-through (FWFT) FIFO.
- Raises a level interrupt toward the pipeline's irq_pins[1] while events are pending. The CPU consumes one event per read strobe.

---
 rtl/kb_event_fifo.sv | 140 ++++++++++++++
 tb/tb_kb_event_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/kb_event_fifo.sv
// Keyboard event queue: converts the level-type key code from kb_driver into
// press/typematic-repeat events, buffers them in a FWFT FIFO and raises a level IRQ.
module kb_event_fifo #(
  parameter int DEPTH         = 8,
  parameter int DELAY_CYCLES  = 25000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               ascii,
  input  logic [4:0]               flags,
  input  logic                     rd_en,
  input  logic                     irq_en,
  output logic [31:0]              kb_word,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     irq
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = ((DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES) - 1;
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  localparam logic [TW-1:0] DLY_LAST = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      key_q, key_d;

  logic [DEPTH-1:0][12:0] mem_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [12:0]     head_q, head_d;
  logic            overflow_q, overflow_d;
  logic            irq_q, irq_d;

  logic            push_req;
  logic [12:0]     push_data;
  logic [TW-1:0]   last_cnt;
  logic            do_push, do_pop, full;

  // Event generator: one push on a new key, then repeats while the same key stays held
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    key_d     = key_q;
    push_req  = 1'b0;
    push_data = {flags, ascii};
    last_cnt  = (state_q == HOLD_REPEAT) ? RPT_LAST : DLY_LAST;
    unique case (state_q)
      IDLE: begin
        if (ascii != 8'd0) begin
          push_req = 1'b1;
          key_d    = ascii;
          timer_d  = '0;
          state_d  = HOLD_DELAY;
        end
      end
      HOLD_DELAY, HOLD_REPEAT: begin
        if (ascii == 8'd0) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (ascii != key_q) begin
          push_req = 1'b1;
          key_d    = ascii;
          timer_d  = '0;
          state_d  = HOLD_DELAY;
        end else if (timer_q == last_cnt) begin
          push_req  = 1'b1;
          push_data = {flags, key_q};
          timer_d   = '0;
          state_d   = HOLD_REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the same cycle pops
  always_comb begin
    full       = (count_q == FULL);
    do_pop     = rd_en && (count_q != '0);
    do_push    = push_req && (!full || do_pop);
    overflow_d = overflow_q | (push_req && full && !do_pop);
    count_d    = count_q + CW'(do_push) - CW'(do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    irq_d      = irq_en && (count_d != '0);
    // The freshly written slot becomes head only when the FIFO drains to it this cycle
    if (count_d == '0)
      head_d = '0;
    else if (do_push && (wr_ptr_q == rd_ptr_d))
      head_d = push_data;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      key_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      key_q      <= key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem_q[wr_ptr_q] <= push_data;
  end

  assign kb_word  = {19'd0, head_q};
  assign count    = count_q;
  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_kb_event_fifo.sv
// Bench for kb_event_fifo: vector table, directed corner sequences and random
// traffic, all compared cycle by cycle against an event-time/queue reference model.
module tb_kb_event_fifo;
  localparam int DEPTH = 4;
  localparam int DLY   = 10;
  localparam int RPT   = 4;

  logic        clk = 1'b0;
  logic        rst, rd_en, irq_en;
  logic [7:0]  ascii;
  logic [4:0]  flags;
  logic [31:0] kb_word;
  logic [2:0]  count;
  logic        overflow, irq;

  kb_event_fifo #(.DEPTH(DEPTH), .DELAY_CYCLES(DLY), .REPEAT_CYCLES(RPT)) dut (
    .clk(clk), .rst(rst), .ascii(ascii), .flags(flags), .rd_en(rd_en),
    .irq_en(irq_en), .kb_word(kb_word), .count(count), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: events occur at press time t0 and at t0+DLY+k*RPT while held
  logic [12:0] mq[$];
  logic        m_ovf = 1'b0;
  logic [7:0]  m_key = 8'd0;
  int          m_t0  = 0;
  int          cyc   = 0;

  typedef struct {
    logic        rd;
    logic [7:0]  a;
    logic [4:0]  f;
    logic        ie;
    logic [31:0] w;
    logic [2:0]  c;
    logic        irq;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic [4:0] f,
                      input logic rd, input logic ie);
    logic        preq;
    logic [12:0] pdata;
    int          age, sz;
    bit          pop;
    rst = r; ascii = a; flags = f; rd_en = rd; irq_en = ie;
    @(posedge clk);
    cyc++;
    preq = 1'b0;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_key = 8'd0;
    end else begin
      if (a == 8'd0) m_key = 8'd0;
      else if (a != m_key) begin
        m_key = a; m_t0 = cyc; preq = 1'b1;
      end else begin
        age = cyc - m_t0;
        if (age >= DLY && ((age - DLY) % RPT) == 0) preq = 1'b1;
      end
      pdata = {f, m_key};
      sz  = mq.size();
      pop = rd && (sz > 0);
      if (pop) void'(mq.pop_front());
      if (preq) begin
        if (sz < DEPTH || pop) mq.push_back(pdata);
        else m_ovf = 1'b1;
      end
    end
    #1;
    chk("model_word", kb_word, (mq.size() != 0) ? {19'd0, mq[0]} : 32'd0);
    chk("model_count", 32'(count), 32'(mq.size()));
    chk("model_irq", 32'(irq), 32'(ie && (mq.size() != 0)));
    chk("model_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    logic [7:0] rk;
    int         hold_left;
    rst = 1'b1; ascii = '0; flags = '0; rd_en = 1'b0; irq_en = 1'b0;

    tbl[0] = '{1'b0, 8'h41, 5'b00001, 1'b1, 32'h0141, 3'd1, 1'b1};
    tbl[1] = '{1'b0, 8'h41, 5'b00001, 1'b1, 32'h0141, 3'd1, 1'b1};
    tbl[2] = '{1'b0, 8'h41, 5'b00001, 1'b1, 32'h0141, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 5'b00000, 1'b1, 32'h0141, 3'd1, 1'b1};
    tbl[4] = '{1'b1, 8'h00, 5'b00000, 1'b1, 32'h0000, 3'd0, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 5'b00000, 1'b1, 32'h0000, 3'd0, 1'b0};
    tbl[6] = '{1'b0, 8'h42, 5'b10000, 1'b0, 32'h1042, 3'd1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 5'b00000, 1'b1, 32'h1042, 3'd1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 5'b00000, 1'b0, 32'h1042, 3'd1, 1'b0};
    tbl[9] = '{1'b1, 8'h00, 5'b00000, 1'b0, 32'h0000, 3'd0, 1'b0};

    // Reset then idle
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    chk("reset_word", kb_word, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);

    // Single press, pop, empty read, irq gating
    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].a, tbl[i].f, tbl[i].rd, tbl[i].ie);
      chk($sformatf("tbl%0d_word", i), kb_word, tbl[i].w);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
    end

    // Long hold: press, +10, +14, +18 fill the FIFO, +22 onwards dropped
    for (int i = 0; i < 30; i++) begin
      step(0, 8'h61, 0, 0, 1);
      chk("hold_count", 32'(count),
          32'(1 + int'(i >= 10) + int'(i >= 14) + int'(i >= 18)));
      chk("hold_ovf", 32'(overflow), 32'(i >= 22));
    end
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk("hold_entry", kb_word, 32'h61);
      step(0, 0, 0, 1, 1);
    end
    chk("hold_drained", 32'(count), 32'd0);
    chk("hold_ovf_sticky", 32'(overflow), 32'd1);

    // Key change mid-delay restarts the delay from the change
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      step(0, (i < 5) ? 8'h61 : 8'h62, 0, 0, 1);
      chk("chg_count", 32'(count), 32'((i < 5) ? 1 : (i < 15) ? 2 : 3));
    end
    step(0, 0, 0, 0, 1);
    chk("chg_e0", kb_word, 32'h61); step(0, 0, 0, 1, 1);
    chk("chg_e1", kb_word, 32'h62); step(0, 0, 0, 1, 1);
    chk("chg_e2", kb_word, 32'h62); step(0, 0, 0, 1, 1);
    chk("chg_empty", kb_word, 32'h0);

    // Full FIFO, push and pop in the same cycle
    step(1, 0, 0, 0, 1);
    for (int v = 8'h31; v <= 8'h34; v++) begin
      step(0, 8'(v), 0, 0, 1);
      step(0, 0, 0, 0, 1);
    end
    chk("full_count", 32'(count), 32'd4);
    step(0, 8'h35, 0, 1, 1);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_head", kb_word, 32'h32);
    chk("pp_ovf", 32'(overflow), 32'd0);
    step(0, 0, 0, 0, 1);
    for (int v = 8'h32; v <= 8'h35; v++) begin
      chk("pp_entry", kb_word, 32'(v));
      step(0, 0, 0, 1, 1);
    end

    // Read while empty
    step(0, 0, 0, 1, 1);
    chk("rd_empty_count", 32'(count), 32'd0);
    chk("rd_empty_word", kb_word, 32'd0);

    // irq_en gating with two pending events
    step(0, 8'h41, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 8'h42, 0, 0, 0); step(0, 0, 0, 0, 0);
    chk("gate_irq_off", 32'(irq), 32'd0);
    chk("gate_count", 32'(count), 32'd2);
    step(0, 0, 0, 0, 1);
    chk("gate_irq_on", 32'(irq), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("gate_irq_drop", 32'(irq), 32'd0);
    chk("gate_count_kept", 32'(count), 32'd2);

    // Reset during repeat with three queued events, key kept held
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(0, 8'h55, 0, 0, 1);
    chk("rstrep_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h55, 0, 0, 1);
      chk("rstrep_zero_count", 32'(count), 32'd0);
      chk("rstrep_zero_irq", 32'(irq), 32'd0);
      chk("rstrep_zero_word", kb_word, 32'd0);
    end
    step(0, 8'h55, 0, 0, 1);
    chk("rstrep_repress", kb_word, 32'h55);
    chk("rstrep_repress_cnt", 32'(count), 32'd1);
    step(0, 0, 0, 0, 1);

    // Random traffic against the model
    rk = 8'd0;
    hold_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_left == 0) begin
        int sel;
        sel = int'($urandom_range(0, 3));
        rk = (sel == 0) ? 8'd0 : 8'(8'h40 + sel);
        hold_left = int'($urandom_range(1, 25));
      end
      hold_left--;
      step(($urandom_range(0, 199) == 0), rk, 5'($urandom_range(0, 31)),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
